mmm_pe_scheduler: RTL and testbench
===================================

Name: mmm_pe_scheduler

Overview:
- Sequences a linear chain of P radix-4 Montgomery processing elements (carry-save word-slice PEs) over a K-bit modular multiplication.
- Each pass streams all operand words through the chain.
- Between passes, the chain output is recirculated through the intermediate buffer.
- Generates operand addresses, B-digit base index, first/last-word flags, PE enable mask, buffer read/write strobes, busy and done.

Parameters:
- K, 1024: operand width in bits.
- W, 16: word size in bits.
- P, 8: number of PEs in the chain; each PE consumes one radix-4 digit of B per pass.
- NW, K/W+1: words per pass, including one overflow word.
- ND, K/2: radix-4 digits of B.
- DW, $clog2(ND)+1: digit-index width.
- AW, $clog2(NW)+1: word-address width.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to begin a multiplication
- stall  input  1  operand memory not ready; freezes word issue
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle completion pulse
- word_addr  output  AW  word index j for A, N and buffer reads
- word_valid  output  1  word_addr valid this cycle; the PE chain advances
- word_first  output  1  j==0: PE clears carries, SM and FF
- word_last  output  1  j==NW-1
- digit_base  output  DW  index of the B digit for PE0 in this pass (pass*P)
- pe_en  output  P  bit k set when digit_base+k < ND
- fb_sel  output  1  0 on the first pass (SR inputs zero); 1 on later passes (SR from buffer)
- buf_we  output  1  write chain output word into the intermediate buffer
- buf_waddr  output  AW  buffer write address

Behaviour:
- Reset: every output is 0; state = IDLE.
- States: IDLE, ISSUE, DRAIN, plus SUB when the optional feature is compiled in.
- IDLE:
  - start==1 → ISSUE next cycle.
  - Clear j, pass and the drain counter.
  - busy rises in the same cycle as the ISSUE entry.
- ISSUE:
  - word_valid = ~stall.
  - j increments only when word_valid==1.
  - word_first and word_last are combinational decodes of j, gated by word_valid.
  - Exit when j==NW-1 is issued with stall==0 → DRAIN with drain counter = 0.
- DRAIN:
  - Lasts exactly 2*P cycles; this is the inter-PE skew of 2 cycles per PE.
  - stall is ignored; word_valid = 0.
  - At the end: if (pass+1)*P < ND → pass++, j = 0, fb_sel = 1, back to ISSUE.
  - Otherwise → IDLE and done = 1 for that cycle; busy falls in the same cycle.
- Buffer write:
  - buf_we is word_valid delayed by 2*P cycles through a shift register.
  - buf_waddr is word_addr delayed by the same amount.
  - Writes therefore continue into DRAIN and never overlap the next pass's first read of the same address.
- Partial final pass (ND not a multiple of P):
  - Masked PEs (pe_en bit = 0) pass SR through unchanged.
  - Issue and drain timing are unchanged.
- start while busy: ignored; no queuing.
- stall during DRAIN: no effect.
- stall held forever: state holds; the delay line keeps shifting.
- rst mid-operation: next cycle IDLE, all outputs 0, no done pulse.
- Latency without stalls: done at cycle 1 + ceil(ND/P)*(NW+2P) after the start cycle (cycle 0).

Optional Feature:
- FINAL_SUB_EN defined:
  - After the last DRAIN, go to SUB instead of IDLE.
  - SUB issues one more sweep j = 0..NW-1 with word_valid, stall honoured, fb_sel = 1 and pe_en = 0.
  - Output sub_active (1 bit) is high throughout SUB; it drives the downstream conditional subtract of N.
  - After the final word, wait 1 cycle, then go to IDLE with done.
  - Adds NW+1 cycles.
- FINAL_SUB_EN not defined: no SUB state; the sub_active port is absent.

Test Plan:
- Test configuration: K=64, W=16, P=4, so NW=5, ND=32, 8 passes.
- Basic run: start pulse at cycle 0, stall=0 → done pulse at cycle 105; 40 word_valid cycles; word_first 8 times; digit_base steps 0,4,...,28.
- Partial pass: ND=30, P=4 → last pass digit_base=28 with pe_en=4'b0011; done at cycle 105.
- Stall: stall=1 for 3 cycles when j==2 in pass 0 → word_addr holds at 2 with word_valid=0; done at cycle 108.
- Reset mid-run: rst at cycle 50 → cycle 51 all outputs 0, state IDLE; a new start at cycle 60 gives done at cycle 165.
- Start while busy: a second start at cycle 20 is ignored → single done at cycle 105; busy stays continuous.
- FINAL_SUB_EN: same stimulus as the basic run → sub_active high for cycles 105–109; done at cycle 111.

Source files
------------

// File: rtl/mmm_pe_scheduler.sv
// Pass/word sequencer for a linear chain of P radix-4 Montgomery PEs.
// Optional final conditional-subtract sweep is compiled in with `define FINAL_SUB_EN.
module mmm_pe_scheduler #(
  parameter int K  = 1024,
  parameter int W  = 16,
  parameter int P  = 8,
  parameter int NW = K / W + 1,
  parameter int ND = K / 2,
  parameter int DW = $clog2(ND) + 1,
  parameter int AW = $clog2(NW) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stall,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] word_addr,
  output logic          word_valid,
  output logic          word_first,
  output logic          word_last,
  output logic [DW-1:0] digit_base,
  output logic [P-1:0]  pe_en,
  output logic          fb_sel,
`ifdef FINAL_SUB_EN
  output logic          sub_active,
`endif
  output logic          buf_we,
  output logic [AW-1:0] buf_waddr
);

  localparam int DL = 2 * P;
  localparam int CW = $clog2(DL) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN
`ifdef FINAL_SUB_EN
    , S_SUB
`endif
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   j_q, j_d;
  logic [DW-1:0]   digit_base_q, digit_base_d;
  logic [CW-1:0]   drain_q, drain_d;
  logic [P-1:0]    pe_en_q, pe_en_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            fb_sel_q, fb_sel_d;
  logic            sub_wait_q, sub_wait_d;
  logic [AW:0]     dl_q [DL];
  logic [AW:0]     dl_d [DL];

  function automatic logic [P-1:0] pe_mask(input logic [DW-1:0] base);
    logic [P-1:0] m;
    m = '0;
    for (int k = 0; k < P; k++) m[k] = (int'(base) + k < ND);
    return m;
  endfunction

  always_comb begin
    word_valid = ~stall & ((state_q == S_ISSUE)
`ifdef FINAL_SUB_EN
                 | ((state_q == S_SUB) & ~sub_wait_q)
`endif
                 );
  end

  assign word_addr  = j_q;
  assign word_first = word_valid & (j_q == '0);
  assign word_last  = word_valid & (j_q == AW'(NW - 1));
  assign busy       = busy_q;
  assign done       = done_q;
  assign digit_base = digit_base_q;
  assign pe_en      = pe_en_q;
  assign fb_sel     = fb_sel_q;
  assign buf_we     = dl_q[DL-1][AW];
  assign buf_waddr  = dl_q[DL-1][AW-1:0];
`ifdef FINAL_SUB_EN
  assign sub_active = (state_q == S_SUB) & ~sub_wait_q;
`endif

  // NOTE: every signal assigned here gets a default first, so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    j_d          = j_q;
    digit_base_d = digit_base_q;
    drain_d      = drain_q;
    pe_en_d      = pe_en_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    fb_sel_d     = fb_sel_q;
    sub_wait_d   = sub_wait_q;

    // The delay line matches the 2-cycle-per-PE skew so writes land behind the reads.
    dl_d[0] = {word_valid, word_addr};
    for (int i = 1; i < DL; i++) dl_d[i] = dl_q[i-1];

    unique case (state_q)
      S_IDLE: begin
        j_d          = '0;
        digit_base_d = '0;
        drain_d      = '0;
        fb_sel_d     = 1'b0;
        pe_en_d      = '0;
        busy_d       = 1'b0;
        sub_wait_d   = 1'b0;
        if (start) begin
          state_d = S_ISSUE;
          busy_d  = 1'b1;
          pe_en_d = pe_mask('0);
        end
      end
      S_ISSUE: begin
        if (word_valid) begin
          if (j_q == AW'(NW - 1)) begin
            j_d     = '0;
            drain_d = '0;
            state_d = S_DRAIN;
          end else begin
            j_d = j_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        drain_d = drain_q + 1'b1;
        if (drain_q == CW'(DL - 1)) begin
          drain_d = '0;
          if (int'(digit_base_q) + P < ND) begin
            digit_base_d = digit_base_q + DW'(P);
            pe_en_d      = pe_mask(digit_base_q + DW'(P));
            fb_sel_d     = 1'b1;
            state_d      = S_ISSUE;
          end else begin
`ifdef FINAL_SUB_EN
            state_d    = S_SUB;
            pe_en_d    = '0;
            fb_sel_d   = 1'b1;
            sub_wait_d = 1'b0;
            j_d        = '0;
`else
            state_d      = S_IDLE;
            done_d       = 1'b1;
            busy_d       = 1'b0;
            fb_sel_d     = 1'b0;
            pe_en_d      = '0;
            digit_base_d = '0;
`endif
          end
        end
      end
`ifdef FINAL_SUB_EN
      S_SUB: begin
        if (sub_wait_q) begin
          state_d      = S_IDLE;
          done_d       = 1'b1;
          busy_d       = 1'b0;
          fb_sel_d     = 1'b0;
          digit_base_d = '0;
          sub_wait_d   = 1'b0;
        end else if (word_valid) begin
          if (j_q == AW'(NW - 1)) begin
            j_d        = '0;
            sub_wait_d = 1'b1;
          end else begin
            j_d = j_q + 1'b1;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: the delay line is reset too, so a mid-run reset cannot leak a stale buf_we.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      j_q          <= '0;
      digit_base_q <= '0;
      drain_q      <= '0;
      pe_en_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fb_sel_q     <= 1'b0;
      sub_wait_q   <= 1'b0;
      for (int i = 0; i < DL; i++) dl_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      state_q      <= state_d;
      j_q          <= j_d;
      digit_base_q <= digit_base_d;
      drain_q      <= drain_d;
      pe_en_q      <= pe_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      fb_sel_q     <= fb_sel_d;
      sub_wait_q   <= sub_wait_d;
      for (int i = 0; i < DL; i++) dl_q[i] <= dl_d[i];
    end
  end

endmodule

// File: tb/tb_mmm_pe_scheduler.sv
// Directed bench for mmm_pe_scheduler: K=64, W=16, P=4 (NW=5, ND=32) plus an ND=30 instance.
module tb_mmm_pe_scheduler;

  localparam int K    = 64;
  localparam int W    = 16;
  localparam int P    = 4;
  localparam int NW   = 5;
  localparam int ND   = 32;
  localparam int ND2  = 30;
  localparam int DW   = 6;
  localparam int AW   = 4;
  localparam int MAXC = 200;
`ifdef FINAL_SUB_EN
  localparam int EXTRA = NW + 1;
  localparam int SUBW  = NW;
  localparam int SUBF  = 1;
`else
  localparam int EXTRA = 0;
  localparam int SUBW  = 0;
  localparam int SUBF  = 0;
`endif

  logic clk, rst, start, stall;

  logic          a_busy, a_done, a_valid, a_first, a_last, a_fb, a_we;
  logic [AW-1:0] a_addr, a_waddr;
  logic [DW-1:0] a_db;
  logic [P-1:0]  a_pe;
  logic          b_busy, b_done, b_valid, b_first, b_last, b_fb, b_we;
  logic [AW-1:0] b_addr, b_waddr;
  logic [DW-1:0] b_db;
  logic [P-1:0]  b_pe;
  logic          a_sub, b_sub;

  mmm_pe_scheduler #(.K(K), .W(W), .P(P), .NW(NW), .ND(ND), .DW(DW), .AW(AW)) u_dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall),
    .busy(a_busy), .done(a_done), .word_addr(a_addr), .word_valid(a_valid),
    .word_first(a_first), .word_last(a_last), .digit_base(a_db), .pe_en(a_pe),
    .fb_sel(a_fb),
`ifdef FINAL_SUB_EN
    .sub_active(a_sub),
`endif
    .buf_we(a_we), .buf_waddr(a_waddr)
  );

  mmm_pe_scheduler #(.K(K), .W(W), .P(P), .NW(NW), .ND(ND2), .DW(DW), .AW(AW)) u_dut_part (
    .clk(clk), .rst(rst), .start(start), .stall(stall),
    .busy(b_busy), .done(b_done), .word_addr(b_addr), .word_valid(b_valid),
    .word_first(b_first), .word_last(b_last), .digit_base(b_db), .pe_en(b_pe),
    .fb_sel(b_fb),
`ifdef FINAL_SUB_EN
    .sub_active(b_sub),
`endif
    .buf_we(b_we), .buf_waddr(b_waddr)
  );

`ifndef FINAL_SUB_EN
  assign a_sub = 1'b0;
  assign b_sub = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic          r_done [MAXC], r_busy [MAXC], r_valid [MAXC], r_first [MAXC];
  logic          r_last [MAXC], r_fb [MAXC], r_we [MAXC], r_sub [MAXC], rb_done [MAXC];
  logic [AW-1:0] r_addr [MAXC], r_waddr [MAXC];
  logic [DW-1:0] r_db [MAXC], rb_db [MAXC];
  logic [P-1:0]  r_pe [MAXC], rb_pe [MAXC];
  logic [63:0]   r_all [MAXC];

  int n_done, done_at, n_valid, n_first, n_last, n_busy, nb_done, b_done_at;

  function automatic logic [63:0] all_a();
    return 64'({a_busy, a_done, a_addr, a_valid, a_first, a_last, a_db, a_pe,
                a_fb, a_we, a_waddr, a_sub});
  endfunction

  // Inputs change #1 after posedge; outputs are recorded on the following negedge.
  task automatic run(input int ncyc, input int stall_at, input int stall_len,
                     input int start2, input int rst_at, input int restart_at);
    for (int c = 0; c < ncyc; c++) begin
      start = (c == 0) || (c == start2) || (c == restart_at);
      stall = (stall_at >= 0) && (c >= stall_at) && (c < stall_at + stall_len);
      rst   = (c == rst_at);
      @(negedge clk);
      r_done[c]  = a_done;  r_busy[c]  = a_busy;  r_valid[c] = a_valid;
      r_first[c] = a_first; r_last[c]  = a_last;  r_fb[c]    = a_fb;
      r_we[c]    = a_we;    r_addr[c]  = a_addr;  r_waddr[c] = a_waddr;
      r_db[c]    = a_db;    r_pe[c]    = a_pe;    r_sub[c]   = a_sub;
      rb_done[c] = b_done;  rb_db[c]   = b_db;    rb_pe[c]   = b_pe;
      r_all[c]   = all_a();
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    stall = 1'b0;
    rst   = 1'b0;
    n_done = 0; done_at = -1; n_valid = 0; n_first = 0; n_last = 0; n_busy = 0;
    nb_done = 0; b_done_at = -1;
    for (int c = 0; c < ncyc; c++) begin
      if (r_done[c]) begin
        n_done++;
        if (done_at < 0) done_at = c;
      end
      if (rb_done[c]) begin
        nb_done++;
        if (b_done_at < 0) b_done_at = c;
      end
      n_valid += int'(r_valid[c]);
      n_first += int'(r_first[c]);
      n_last  += int'(r_last[c]);
      n_busy  += int'(r_busy[c]);
    end
  endtask

  initial begin
    start = 1'b0;
    stall = 1'b0;
    rst   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_outputs_zero", all_a(), 64'd0);
    @(posedge clk);
    #1;

    // Basic run, full and partial instances together.
    run(120, -1, 0, -1, -1, -1);
    check("basic_done_cycle", 64'(done_at), 64'(105 + EXTRA));
    check("basic_done_count", 64'(n_done), 64'd1);
    check("basic_valid_count", 64'(n_valid), 64'(40 + SUBW));
    check("basic_first_count", 64'(n_first), 64'(8 + SUBF));
    check("basic_last_count", 64'(n_last), 64'(8 + SUBF));
    check("basic_busy_cycles", 64'(n_busy), 64'(104 + EXTRA));
    check("basic_busy_c0", 64'(r_busy[0]), 64'd0);
    check("basic_busy_c1", 64'(r_busy[1]), 64'd1);
    for (int p = 0; p < 8; p++)
      check($sformatf("digit_base_pass%0d", p), 64'(r_db[1 + 13 * p]), 64'(4 * p));
    check("fb_sel_pass0", 64'(r_fb[1]), 64'd0);
    check("fb_sel_pass1", 64'(r_fb[14]), 64'd1);
    check("pe_en_full_last", 64'(r_pe[92]), 64'hf);
    check("buf_we_before", 64'(r_we[8]), 64'd0);
    check("buf_we_first", 64'(r_we[9]), 64'd1);
    check("buf_waddr_first", 64'(r_waddr[9]), 64'd0);
    check("buf_we_last", 64'(r_we[13]), 64'd1);
    check("buf_waddr_last", 64'(r_waddr[13]), 64'd4);
    check("buf_we_gap", 64'(r_we[14]), 64'd0);
    check("buf_we_pass1", 64'(r_we[22]), 64'd1);
    check("valid_in_drain", 64'(r_valid[6]), 64'd0);
    check("part_db_last", 64'(rb_db[92]), 64'd28);
    check("part_pe_en_last", 64'(rb_pe[92]), 64'b0011);
    check("part_pe_en_prev", 64'(rb_pe[79]), 64'hf);
    check("part_done_cycle", 64'(b_done_at), 64'(105 + EXTRA));
    check("part_done_count", 64'(nb_done), 64'd1);
`ifdef FINAL_SUB_EN
    check("sub_off_104", 64'(r_sub[104]), 64'd0);
    for (int c = 105; c <= 109; c++)
      check($sformatf("sub_on_%0d", c), 64'(r_sub[c]), 64'd1);
    check("sub_off_110", 64'(r_sub[110]), 64'd0);
`endif

    // Stall for 3 cycles while j==2 in pass 0.
    run(125, 3, 3, -1, -1, -1);
    for (int c = 3; c <= 5; c++) begin
      check($sformatf("stall_addr_c%0d", c), 64'(r_addr[c]), 64'd2);
      check($sformatf("stall_valid_c%0d", c), 64'(r_valid[c]), 64'd0);
    end
    check("stall_resume_valid", 64'(r_valid[6]), 64'd1);
    check("stall_resume_addr", 64'(r_addr[6]), 64'd2);
    check("stall_buf_we_hole", 64'(r_we[11]), 64'd0);
    check("stall_buf_we_resume", 64'(r_we[14]), 64'd1);
    check("stall_buf_waddr", 64'(r_waddr[14]), 64'd2);
    check("stall_done_cycle", 64'(done_at), 64'(108 + EXTRA));

    // Reset mid-run, then a fresh start.
    run(180, -1, 0, -1, 50, 60);
    check("rst_busy_before", 64'(r_busy[50]), 64'd1);
    check("rst_outputs_zero", r_all[51], 64'd0);
    check("rst_idle_c59", r_all[59], 64'd0);
    check("rst_done_cycle", 64'(done_at), 64'(165 + EXTRA));
    check("rst_done_count", 64'(n_done), 64'd1);

    // Second start while busy is ignored.
    run(120, -1, 0, 20, -1, -1);
    check("busy_start_done_cycle", 64'(done_at), 64'(105 + EXTRA));
    check("busy_start_done_count", 64'(n_done), 64'd1);
    check("busy_start_busy_cycles", 64'(n_busy), 64'(104 + EXTRA));
    check("busy_start_valid_count", 64'(n_valid), 64'(40 + SUBW));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
